// File: rtl/gost_nonce_scan.sv
// Nonce sequencer and result checker wrapped around the GOST-512 core.
// Define GOST_HASH_COUNT_EN to add the hash_count output.
module gost_nonce_scan #(
  parameter int HASH_LATENCY = 96,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [479:0] header,
  input  logic [31:0]  nonce_start,
  input  logic [31:0]  nonce_end,
  input  logic [63:0]  target,
  output logic [511:0] core_data,
  input  logic [511:0] core_hash,
  output logic         busy,
  output logic         done,
  output logic         gn_valid,
  output logic [31:0]  gn_nonce,
  input  logic         gn_ready,
  output logic         gn_overflow
`ifdef GOST_HASH_COUNT_EN
  ,
  output logic [47:0]  hash_count
`endif
);

  localparam int CW = $clog2(HASH_LATENCY) + 1;
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DRAIN
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic                    r_slot;
  logic [479:0]            r_header;
  logic [31:0]             r_nonce_end;
  logic [63:0]             r_target;
  logic [31:0]             r_issue;
  logic [31:0]             r_check;
  logic [HASH_LATENCY-1:0] r_tags;
  logic [CW-1:0]           r_inflight;
  logic [511:0]            r_core_data;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_overflow;
  logic [31:0]             r_mem [FIFO_DEPTH];
  logic [AW:0]             r_wptr;
  logic [AW:0]             r_rptr;

  logic w_accept;
  logic w_issue;
  logic w_done_nxt;
  logic w_last;
  logic w_drained;
  logic w_tag_out;
  logic w_win;
  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push_ok;
  logic w_drop;
  logic w_unused;

  assign w_unused  = ^core_hash[447:0];
  assign w_last    = (r_issue == r_nonce_end);
  assign w_drained = (r_tags == '0) && (r_inflight == '0);
  assign w_tag_out = r_tags[HASH_LATENCY-1];
  assign w_win     = w_tag_out &&
                     (core_hash[511:448] <= r_target);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (start)             w_state_nxt = S_SCAN;
      S_SCAN:  if (w_issue && w_last) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_drained)         w_state_nxt = S_IDLE;
      default:                        w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_accept   = 1'b0;
    w_issue    = 1'b0;
    w_done_nxt = 1'b0;
    unique case (1'b1)
      (r_state == S_IDLE):  w_accept   = start;
      (r_state == S_SCAN):  w_issue    = r_slot;
      (r_state == S_DRAIN): w_done_nxt = w_drained;
      default: ;
    endcase
  end

  // Results return in issue order, so a counter recovers each nonce.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot      <= 1'b0;
      r_header    <= '0;
      r_nonce_end <= '0;
      r_target    <= '0;
      r_issue     <= '0;
      r_check     <= '0;
      r_tags      <= '0;
      r_inflight  <= '0;
      r_core_data <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_slot <= ~r_slot;
      r_tags <= {r_tags[HASH_LATENCY-2:0], w_issue};
      if (w_accept) begin
        r_header    <= header;
        r_nonce_end <= nonce_end;
        r_target    <= target;
        r_issue     <= nonce_start;
      end else if (w_issue) begin
        r_issue <= r_issue + 32'd1;
      end
      if (w_issue) r_core_data <= {r_header, r_issue};
      if (w_accept)       r_check <= nonce_start;
      else if (w_tag_out) r_check <= r_check + 32'd1;
      unique case ({w_issue, w_tag_out})
        2'b10:   r_inflight <= r_inflight + CW'(1);
        2'b01:   r_inflight <= r_inflight - CW'(1);
        default: r_inflight <= r_inflight;
      endcase
      if (w_accept)        r_busy <= 1'b1;
      else if (w_done_nxt) r_busy <= 1'b0;
      r_done <= w_done_nxt;
      if (w_drop)        r_overflow <= 1'b1;
      else if (w_accept) r_overflow <= 1'b0;
    end
  end

  assign w_empty   = (r_wptr == r_rptr);
  assign w_full    = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop     = gn_ready && !w_empty;
  assign w_push_ok = w_win && (!w_full || w_pop);
  assign w_drop    = w_win && w_full && !w_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wptr[AW-1:0]] <= r_check;
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
    end
  end

`ifdef GOST_HASH_COUNT_EN
  logic [47:0] r_hash_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_hash_count <= '0;
    else if (w_tag_out) r_hash_count <= r_hash_count + 48'd1;
  end

  assign hash_count = r_hash_count;
`endif

  assign core_data   = r_core_data;
  assign busy        = r_busy;
  assign done        = r_done;
  assign gn_valid    = !w_empty;
  assign gn_nonce    = r_mem[r_rptr[AW-1:0]];
  assign gn_overflow = r_overflow;

endmodule

// File: tb/tb_gost_nonce_scan.sv
// Directed bench for gost_nonce_scan with a delay-line core model.
module tb_gost_nonce_scan;

  localparam int L = 96;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [479:0] header = {15{32'h1234_5678}};
  logic [31:0]  nonce_start = '0;
  logic [31:0]  nonce_end = '0;
  logic [63:0]  target = '0;
  logic [511:0] core_data;
  logic [511:0] core_hash;
  logic         busy;
  logic         done;
  logic         gn_valid;
  logic [31:0]  gn_nonce;
  logic         gn_ready = 1'b0;
  logic         gn_overflow;

  int total = 0;
  int bad = 0;
  int mode = 0;

  logic [31:0] dl [L-1];
  logic [63:0] w_hi;

  int iss_v[$];
  int iss_c[$];
  int pops[$];
  int done_n;
  int done_c;
  logic busy_seen;

  gost_nonce_scan #(
    .HASH_LATENCY(L),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .header(header),
    .nonce_start(nonce_start),
    .nonce_end(nonce_end),
    .target(target),
    .core_data(core_data),
    .core_hash(core_hash),
    .busy(busy),
    .done(done),
    .gn_valid(gn_valid),
    .gn_nonce(gn_nonce),
    .gn_ready(gn_ready),
    .gn_overflow(gn_overflow)
  );

  always #5 clk = ~clk;

  // Core model: L-1 register stages after the core_data register.
  always @(posedge clk) begin
    dl[0] <= core_data[31:0];
    for (int i = 1; i < L - 1; i++) dl[i] <= dl[i-1];
  end

  always_comb begin
    w_hi = '1;
    if (mode == 2) w_hi = '0;
    else if (mode == 1 && dl[L-2] == 32'h12) w_hi = '0;
    core_hash = {w_hi, 448'h0};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_chk(input string tag, input logic [31:0] exp);
    chk({tag, "_valid"}, 64'(gn_valid), 64'd1);
    chk({tag, "_nonce"}, 64'(gn_nonce), 64'(exp));
    gn_ready = 1'b1;
    tick();
    gn_ready = 1'b0;
  endtask

  task automatic run(input logic [31:0] ns,
                     input logic [31:0] ne,
                     input int restart_c,
                     input int maxc);
    logic [31:0] prev;
    int c;
    int tail;
    iss_v.delete();
    iss_c.delete();
    pops.delete();
    done_n = 0;
    done_c = -1;
    nonce_start = ns;
    nonce_end = ne;
    target = 64'h0;
    prev = core_data[31:0];
    start = 1'b1;
    tick();
    start = 1'b0;
    busy_seen = busy;
    c = 0;
    tail = -1;
    while (c < maxc && tail != 0) begin
      tick();
      c++;
      if (core_data[31:0] !== prev) begin
        iss_v.push_back(int'(core_data[31:0]));
        iss_c.push_back(c);
        prev = core_data[31:0];
      end
      if (done) begin
        done_n++;
        done_c = c;
        if (tail < 0) tail = L + 20;
      end
      if (gn_valid && gn_ready) pops.push_back(int'(gn_nonce));
      start = (c == restart_c);
      if (tail > 0) tail--;
    end
    start = 1'b0;
    chk("done_seen", 64'(done_c >= 0), 64'd1);
  endtask

  initial begin
    int c;
    int dn;

    repeat (3) tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_valid", 64'(gn_valid), 64'd0);
    chk("rst_nonce", 64'(gn_nonce), 64'd0);
    chk("rst_ovf", 64'(gn_overflow), 64'd0);
    chk("rst_data", 64'(core_data == '0), 64'd1);
    rst_n = 1'b1;
    tick();

    // Basic scan, nothing wins.
    mode = 0;
    run(32'h10, 32'h13, -1, 1000);
    chk("t1_busy", 64'(busy_seen), 64'd1);
    chk("t1_n", 64'(iss_v.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      chk("t1_iss", 64'(iss_v[i]), 64'(32'h10 + i));
    for (int i = 0; i < 3; i++)
      chk("t1_gap", 64'(iss_c[i+1] - iss_c[i]), 64'd2);
    chk("t1_hdr", 64'(core_data[511:32] === header), 64'd1);
    chk("t1_done_n", 64'(done_n), 64'd1);
    chk("t1_done_lat", 64'(done_c - iss_c[3]), 64'(L + 1));
    chk("t1_valid", 64'(gn_valid), 64'd0);
    chk("t1_busy_end", 64'(busy), 64'd0);

    // Only 0x12 wins; popped straight away.
    mode = 1;
    gn_ready = 1'b1;
    run(32'h10, 32'h13, -1, 1000);
    gn_ready = 1'b0;
    chk("t2_pops", 64'(pops.size()), 64'd1);
    chk("t2_nonce", 64'(pops[0]), 64'h12);
    chk("t2_ovf", 64'(gn_overflow), 64'd0);
    chk("t2_valid", 64'(gn_valid), 64'd0);

    // Wrap through zero, FIFO just fits.
    mode = 2;
    run(32'hFFFF_FFFE, 32'h1, -1, 1000);
    chk("t3_n", 64'(iss_v.size()), 64'd4);
    chk("t3_ovf", 64'(gn_overflow), 64'd0);
    pop_chk("t3_p0", 32'hFFFF_FFFE);
    pop_chk("t3_p1", 32'hFFFF_FFFF);
    pop_chk("t3_p2", 32'h0);
    pop_chk("t3_p3", 32'h1);
    chk("t3_empty", 64'(gn_valid), 64'd0);

    run(32'hFFFF_FFFE, 32'h2, -1, 1000);
    chk("t3b_ovf", 64'(gn_overflow), 64'd1);
    pop_chk("t3b_p0", 32'hFFFF_FFFE);
    pop_chk("t3b_p1", 32'hFFFF_FFFF);
    pop_chk("t3b_p2", 32'h0);
    pop_chk("t3b_p3", 32'h1);
    chk("t3b_empty", 64'(gn_valid), 64'd0);

    // Single-nonce scan with a start pulse while busy.
    gn_ready = 1'b1;
    run(32'h55, 32'h55, 3, 1000);
    gn_ready = 1'b0;
    chk("t4_n", 64'(iss_v.size()), 64'd1);
    chk("t4_iss", 64'(iss_v[0]), 64'h55);
    chk("t4_done_n", 64'(done_n), 64'd1);
    chk("t4_pops", 64'(pops.size()), 64'd1);
    chk("t4_pop", 64'(pops[0]), 64'h55);
    chk("t4_ovf", 64'(gn_overflow), 64'd0);

    // Reset in the middle of a long scan.
    mode = 2;
    nonce_start = 32'h100;
    nonce_end = 32'h1FF;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (L + 40) tick();
    chk("t5_pre_valid", 64'(gn_valid), 64'd1);
    chk("t5_pre_ovf", 64'(gn_overflow), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_valid", 64'(gn_valid), 64'd0);
    chk("t5_ovf", 64'(gn_overflow), 64'd0);
    chk("t5_data", 64'(core_data == '0), 64'd1);
    tick();
    rst_n = 1'b1;
    dn = 0;
    repeat (2 * L) begin
      tick();
      if (done) dn++;
    end
    chk("t5_no_done", 64'(dn), 64'd0);
    chk("t5_idle_valid", 64'(gn_valid), 64'd0);
    run(32'h300, 32'h301, -1, 1000);
    chk("t5_n", 64'(iss_v.size()), 64'd2);
    chk("t5_iss", 64'(iss_v[0]), 64'h300);
    chk("t5_done_n", 64'(done_n), 64'd1);
    pop_chk("t5_p0", 32'h300);
    pop_chk("t5_p1", 32'h301);
    chk("t5_empty", 64'(gn_valid), 64'd0);

    // Push and pop together while the FIFO is full.
    nonce_start = 32'h400;
    nonce_end = 32'h404;
    start = 1'b1;
    tick();
    start = 1'b0;
    c = 0;
    while (!gn_valid && c < 400) begin
      tick();
      c++;
    end
    chk("t6_first", 64'(gn_valid), 64'd1);
    repeat (7) tick();
    gn_ready = 1'b1;
    tick();
    gn_ready = 1'b0;
    chk("t6_head", 64'(gn_nonce), 64'h401);
    chk("t6_ovf", 64'(gn_overflow), 64'd0);
    c = 0;
    while (!done && c < 400) begin
      tick();
      c++;
    end
    chk("t6_done", 64'(done), 64'd1);
    chk("t6_ovf_end", 64'(gn_overflow), 64'd0);
    pop_chk("t6_p0", 32'h401);
    pop_chk("t6_p1", 32'h402);
    pop_chk("t6_p2", 32'h403);
    pop_chk("t6_p3", 32'h404);
    chk("t6_empty", 64'(gn_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
